ifetch_irq_sched: RTL
=====================

// Module: ifetch_irq_sched
// PURPOSE
//  Sequences PC redirects into the instruction fetcher. After reset it holds the reset-vector
//  redirect for a fixed number of cycles. It latches and masks external interrupt requests and
//  round-robin arbitrates among them. On a grant it issues a one-cycle interrupt redirect and
//  saves the return PC. Its outputs drive the fetcher's rst_flag/rst_addr/int_flag/int_addr.
// PARAMETERS
//  N_IRQ      8             number of interrupt request lines (2..16)
//  RST_VEC    32'h00000000  reset vector driven on rst_addr
//  INT_BASE   32'h00000100  interrupt vector table base; vector = INT_BASE + id*4
//  RST_CYC    2             cycles rst_flag is held asserted after reset release (>=2)
// PORTS
//  clk         in   1      system clock; all state updates on rising edge
//  rst         in   1      asynchronous, active-high reset
//  irq         in   N_IRQ  interrupt requests, level or pulse, synchronous to clk
//  mask_we     in   1      write enable for mask register
//  mask_wdata  in   N_IRQ  new mask value (1 = enabled)
//  pc          in   32     current fetch PC from fetcher
//  mret        in   1      one-cycle pulse from decode: return from interrupt
//  rst_flag    out  1      ACTIVE LOW; selects rst_addr as next PC
//  rst_addr    out  32     reset vector (constant RST_VEC)
//  int_flag    out  1      ACTIVE LOW; selects int_addr as next PC
//  int_addr    out  32     redirect target: vector on entry, epc on return
//  epc         out  32     saved return PC
//  int_id      out  4      id of interrupt in service
//  busy        out  1      high while an interrupt is in service
// BEHAVIOUR
//  - Reset (async): state=BOOT, rst_flag=0, int_flag=1, cnt=0, pending=0, mask=0, rr_ptr=0,
//    epc=0, int_id=0, busy=0, int_addr=INT_BASE. Reset mid-operation aborts everything, no residue.
//  - FSM states:
//    - BOOT: rst_flag=0 for RST_CYC cycles after rst falls, counting cnt. Then go to RUN and set rst_flag=1.
//    - RUN: on any (pending & mask) != 0, go to ENTRY. The arbiter grant is registered into int_id.
//      epc <= pc. int_addr <= INT_BASE + {id,2'b00}.
//    - ENTRY: int_flag=0 for exactly one cycle; busy=1. Then go to SERVE.
//    - SERVE: int_flag=1. On mret, int_addr <= epc and go to RETURN. No nesting; new grants are blocked.
//    - RETURN: int_flag=0 for one cycle, then go to RUN; busy=0 on exit.
//  - Flag/address outputs are registered: glitch-free and stable across a full clk period.
//  - Only int_flag or rst_flag is low in any cycle, never both.
//  - pending[i] is set when irq[i]=1 in any cycle, masked or not.
//    - Cleared only when i is granted (the transition out of RUN).
//    - Set wins over clear in the same cycle only for other bits.
//    - A held-high granted line re-pends next cycle.
//  - Arbitration: round-robin over pending & mask, searching from rr_ptr upward with wrap.
//    - On grant, rr_ptr <= id+1, wrapping N_IRQ-1 -> 0.
//    - Grant latency: irq high at edge k -> pending at k+1 -> ENTRY at k+2 -> redirect edge k+3.
//  - mask_we takes effect the next cycle. Unmasking a pending line makes it eligible immediately after.
//  - mret outside SERVE is ignored. mret and a new irq in the same cycle: return first, irq
//    serviced from RUN afterwards. mret during ENTRY is ignored.
//  - Width rules: int_addr arithmetic is 32-bit modulo (INT_BASE + id*4 wraps silently).
//    int_id is zero-extended to 4 bits.
// STRUCTURE
//  - Shared include: FSM state encodings (BOOT/RUN/ENTRY/SERVE/RETURN, 3-bit) and the
//    active-low flag constants (FLAG_ON=1'b0, FLAG_OFF=1'b1), reused by other redirect sources.
//  - One sub-module: rr_arbiter (N_IRQ requests, ptr in -> one-hot grant, encoded id, valid).
//    Combinational; the pointer register lives in ifetch_irq_sched.
// TESTING
//  - Reset: rst high 3 cycles then low, RST_CYC=2 -> rst_flag=0 for exactly 2 edges after release,
//    then 1. rst_addr=0. int_flag=1 throughout.
//  - Single irq: mask=8'h04, pc=32'h40, irq[2] pulse one cycle -> 3 edges later int_flag=0 for
//    1 cycle, int_addr=32'h108, epc=32'h40, int_id=2, busy=1.
//  - Return: in SERVE, mret pulse -> next cycle int_flag=0 for 1 cycle with int_addr=32'h40.
//    Then RUN, busy=0.
//  - Round robin: mask=8'hFF, irq[1] and irq[5] held high, rr_ptr=0 -> service order 1,5,1,5
//    across successive mret cycles.
//  - Masked pending: mask=0, irq[3] pulse -> no redirect for 20 cycles. Then write mask=8'h08 ->
//    entry with int_id=3 within 2 cycles.
//  - Reset mid-service: rst asserted in SERVE -> busy=0, int_flag=1, pending=0, rst_flag=0
//    immediately (async). BOOT sequence repeats.

Source files
------------

// File: rtl/ifetch_irq_sched_pkg.sv
// Shared encodings for the fetch redirect sources:
// FSM states, active-low flag levels and vector arithmetic.
package ifetch_irq_sched_pkg;

    localparam logic [2:0] ST_BOOT   = 3'd0;
    localparam logic [2:0] ST_RUN    = 3'd1;
    localparam logic [2:0] ST_ENTRY  = 3'd2;
    localparam logic [2:0] ST_SERVE  = 3'd3;
    localparam logic [2:0] ST_RETURN = 3'd4;

    localparam logic FLAG_ON  = 1'b0;
    localparam logic FLAG_OFF = 1'b1;

    localparam int ID_W = 4;

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
    } grant_t;

    // Vector table lookup, 32-bit modulo by construction.
    function automatic logic [31:0] vec_addr(
        input logic [31:0]     base,
        input logic [ID_W-1:0] id
    );
        return base + {26'd0, id, 2'b00};
    endfunction

endpackage

// File: rtl/ifetch_irq_sched_if.sv
// Bundle between the redirect scheduler, the
// interrupt sources and the instruction fetcher.
interface ifetch_irq_sched_if #(
    parameter int N_IRQ = 8
);
    logic [N_IRQ-1:0] irq;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_wdata;
    logic [31:0]      pc;
    logic             mret;
    logic             rst_flag;
    logic [31:0]      rst_addr;
    logic             int_flag;
    logic [31:0]      int_addr;
    logic [31:0]      epc;
    logic [3:0]       int_id;
    logic             busy;

    modport master (
        output irq, mask_we, mask_wdata, pc, mret,
        input  rst_flag, rst_addr, int_flag,
        input  int_addr, epc, int_id, busy
    );

    modport slave (
        input  irq, mask_we, mask_wdata, pc, mret,
        output rst_flag, rst_addr, int_flag,
        output int_addr, epc, int_id, busy
    );
endinterface

// File: rtl/ifetch_irq_sched_rr_arbiter.sv
// Combinational round-robin arbiter: first request
// at or above ptr_i (with wrap) wins.
module rr_arbiter
    import ifetch_irq_sched_pkg::*;
#(
    parameter int N_IRQ = 8
) (
    input  logic [N_IRQ-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    output logic [N_IRQ-1:0] gnt_o,
    output grant_t           grant_o
);

    always_comb begin
        int idx;
        idx     = 0;
        gnt_o   = '0;
        grant_o = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            idx = (int'(ptr_i) + i) % N_IRQ;
            if (!grant_o.vld && req_i[idx]) begin
                grant_o.vld = 1'b1;
                grant_o.id  = ID_W'(idx);
                gnt_o[idx]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ifetch_irq_sched.sv
// PC redirect sequencer: reset-vector hold after reset,
// then masked round-robin interrupt entry and return.
module ifetch_irq_sched
    import ifetch_irq_sched_pkg::*;
#(
    parameter int          N_IRQ    = 8,
    parameter logic [31:0] RST_VEC  = 32'h0000_0000,
    parameter logic [31:0] INT_BASE = 32'h0000_0100,
    parameter int          RST_CYC  = 2
) (
    input  logic                clk,
    input  logic                rst,
    ifetch_irq_sched_if.slave   bus
);

    localparam int CNT_W = $clog2(RST_CYC + 1);

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N_IRQ-1:0] pend_q, pend_d;
    logic [N_IRQ-1:0] mask_q, mask_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [31:0]      epc_q, epc_d;
    logic [ID_W-1:0]  int_id_q, int_id_d;
    logic             busy_q, busy_d;
    logic [31:0]      int_addr_q, int_addr_d;
    logic             rst_flag_q, rst_flag_d;
    logic             int_flag_q, int_flag_d;

    logic [N_IRQ-1:0] gnt_oh;
    logic [N_IRQ-1:0] clr;
    grant_t           grant;

    rr_arbiter #(
        .N_IRQ (N_IRQ)
    ) u_arb (
        .req_i   (pend_q & mask_q),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (gnt_oh),
        .grant_o (grant)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rr_ptr_d   = rr_ptr_q;
        epc_d      = epc_q;
        int_id_d   = int_id_q;
        busy_d     = busy_q;
        int_addr_d = int_addr_q;
        rst_flag_d = rst_flag_q;
        int_flag_d = int_flag_q;
        clr        = '0;
        mask_d     = bus.mask_we ? bus.mask_wdata : mask_q;

        unique case (state_q)
            ST_BOOT: begin
                if (cnt_q == CNT_W'(RST_CYC - 1)) begin
                    state_d    = ST_RUN;
                    rst_flag_d = FLAG_OFF;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (grant.vld) begin
                    state_d    = ST_ENTRY;
                    clr        = gnt_oh;
                    int_id_d   = grant.id;
                    epc_d      = bus.pc;
                    int_addr_d = vec_addr(INT_BASE, grant.id);
                    int_flag_d = FLAG_ON;
                    busy_d     = 1'b1;
                    rr_ptr_d   = (grant.id == ID_W'(N_IRQ - 1))
                               ? '0 : grant.id + 1'b1;
                end
            end
            ST_ENTRY: begin
                state_d    = ST_SERVE;
                int_flag_d = FLAG_OFF;
            end
            ST_SERVE: begin
                if (bus.mret) begin
                    state_d    = ST_RETURN;
                    int_addr_d = epc_q;
                    int_flag_d = FLAG_ON;
                end
            end
            ST_RETURN: begin
                state_d    = ST_RUN;
                int_flag_d = FLAG_OFF;
                busy_d     = 1'b0;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase

        // The granted line is cleared even if still high; it re-pends next edge.
        pend_d = (pend_q | bus.irq) & ~clr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            cnt_q      <= '0;
            pend_q     <= '0;
            mask_q     <= '0;
            rr_ptr_q   <= '0;
            epc_q      <= '0;
            int_id_q   <= '0;
            busy_q     <= 1'b0;
            int_addr_q <= INT_BASE;
            rst_flag_q <= FLAG_ON;
            int_flag_q <= FLAG_OFF;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            rr_ptr_q   <= rr_ptr_d;
            epc_q      <= epc_d;
            int_id_q   <= int_id_d;
            busy_q     <= busy_d;
            int_addr_q <= int_addr_d;
            rst_flag_q <= rst_flag_d;
            int_flag_q <= int_flag_d;
        end
    end

    assign bus.rst_flag = rst_flag_q;
    assign bus.rst_addr = RST_VEC;
    assign bus.int_flag = int_flag_q;
    assign bus.int_addr = int_addr_q;
    assign bus.epc      = epc_q;
    assign bus.int_id   = 4'(int_id_q);
    assign bus.busy     = busy_q;

endmodule
